// File: rtl/hazard_control.sv
// rtl/hazard_control.sv - pipeline hazard unit: forwarding, load-use stall, branch flush, memory-wait FSM
// Optional feature macro: HAZARD_PERF_CNT_EN (adds StallCycles / FlushCount performance counters)
module hazard_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MemTimeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount
`endif
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ERROR = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [7:0] r_wait_cnt;
    logic       w_mem_wait;
    logic       w_load_use;
    logic       w_hold;

    assign w_mem_wait = MemReqM & ~MemReadyM;

    assign w_load_use = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));

    // Whole pipeline freezes while memory is outstanding, while waiting, or after a timeout.
    // The completion cycle of WAIT (MemReadyM high) is deliberately not a hold cycle.
    assign w_hold = w_mem_wait ||
                    (r_state == S_ERROR) ||
                    ((r_state == S_WAIT) && !MemReadyM);

    // Forwarding: Memory stage has priority over Writeback; x0 is never forwarded
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
            ForwardAE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
            ForwardAE = 2'b01;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
            ForwardBE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
            ForwardBE = 2'b01;
    end

    // Stall/flush decode; a held pipeline suppresses flushes so a pending branch is re-presented later
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (w_hold) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else begin
            StallF = w_load_use;
            StallD = w_load_use;
            FlushD = PCSrcE;
            FlushE = w_load_use | PCSrcE;
        end
    end

    // Next-state logic for the memory-wait tracker
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RUN: begin
                if (w_mem_wait)
                    w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (MemReadyM)
                    w_next_state = S_RUN;
                else if (r_wait_cnt == 8'hFF)
                    w_next_state = S_ERROR;
            end
            S_ERROR: w_next_state = S_ERROR;
            default: w_next_state = S_RUN;
        endcase
    end

    // State register; ERROR is left only through rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_RUN;
        else
            r_state <= w_next_state;
    end

    // Wait counter: cleared in RUN, counts WAIT cycles, saturates at 255 where ERROR takes over
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_wait_cnt <= 8'd0;
        else if (r_state == S_RUN)
            r_wait_cnt <= 8'd0;
        else if ((r_state == S_WAIT) && (r_wait_cnt != 8'hFF))
            r_wait_cnt <= r_wait_cnt + 8'd1;
    end

    assign MemTimeout = (r_state == S_ERROR);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    // Performance counters: stalled-fetch cycles and branch-caused Execute flushes, wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (StallF)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (FlushE && PCSrcE)
                r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign StallCycles = r_stall_cycles;
    assign FlushCount  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// tb/tb_hazard_control.sv - self-checking bench for hazard_control with a behavioural reference model
module tb_hazard_control;

    logic       clk;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, MemTimeout;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCycles, FlushCount;
`endif

    int checks   = 0;
    int failures = 0;

    bit          m_waiting;
    int          m_wait_cycles;
    bit          m_timeout;
    logic [31:0] m_stall_cnt;
    logic [31:0] m_flush_cnt;

    hazard_control dut (
        .clk        (clk),
        .rst        (rst),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .ResultSrcE (ResultSrcE),
        .PCSrcE     (PCSrcE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .MemReqM    (MemReqM),
        .MemReadyM  (MemReadyM),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .MemTimeout (MemTimeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .StallCycles(StallCycles),
        .FlushCount (FlushCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Expected {StallF,StallD,StallE,StallM} and {FlushD,FlushE} from the rules and model state
    task automatic expect_ctl(output logic [3:0] st, output logic [1:0] fl);
        bit lu, hold;
        lu   = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        hold = (MemReqM && !MemReadyM) || m_timeout || (m_waiting && !MemReadyM);
        if (hold) begin
            st = 4'b1111;
            fl = 2'b00;
        end else begin
            st = {lu, lu, 2'b00};
            fl = {PCSrcE, lu | PCSrcE};
        end
    endtask

    task automatic model_reset();
        m_waiting     = 0;
        m_wait_cycles = 0;
        m_timeout     = 0;
        m_stall_cnt   = 0;
        m_flush_cnt   = 0;
    endtask

    task automatic check_now(input string tag);
        logic [3:0] st;
        logic [1:0] fl;
        expect_ctl(st, fl);
        chk({tag, ".fwdA"}, {30'd0, ForwardAE}, {30'd0, fwd(Rs1E)});
        chk({tag, ".fwdB"}, {30'd0, ForwardBE}, {30'd0, fwd(Rs2E)});
        chk({tag, ".stall"}, {28'd0, StallF, StallD, StallE, StallM}, {28'd0, st});
        chk({tag, ".flush"}, {30'd0, FlushD, FlushE}, {30'd0, fl});
        chk({tag, ".timeout"}, {31'd0, MemTimeout}, {31'd0, m_timeout});
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, ".stallcyc"}, StallCycles, m_stall_cnt);
        chk({tag, ".flushcnt"}, FlushCount, m_flush_cnt);
`endif
    endtask

    // Advance one clock edge and update the model with the inputs present at that edge
    task automatic tick();
        logic [3:0] st;
        logic [1:0] fl;
        expect_ctl(st, fl);
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (st[3]) m_stall_cnt = m_stall_cnt + 1;
            if (fl[0] && PCSrcE) m_flush_cnt = m_flush_cnt + 1;
            if (!m_timeout) begin
                if (!m_waiting) begin
                    if (MemReqM && !MemReadyM) begin
                        m_waiting     = 1;
                        m_wait_cycles = 0;
                    end
                end else if (MemReadyM) begin
                    m_waiting = 0;
                end else if (m_wait_cycles == 255) begin
                    m_timeout = 1;
                    m_waiting = 0;
                end else begin
                    m_wait_cycles++;
                end
            end
        end
    endtask

    task automatic step(input string tag);
        #3;
        check_now(tag);
        tick();
    endtask

    task automatic idle();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        ResultSrcE = 2'b00;
        {PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM} = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        #3;
        check_now("reset");
        chk("reset.stall_all", {28'd0, StallF, StallD, StallE, StallM}, 32'd0);
        tick();
        rst = 1'b0;
        step("idle");

        // Forwarding priority and x0 exclusion
        RegWriteM = 1; RegWriteW = 1; RdM = 5; RdW = 5; Rs1E = 5;
        #3; chk("fwd_prio", {30'd0, ForwardAE}, 32'd2); #0; tick();
        RdM = 0; RdW = 0; Rs1E = 0;
        #3; chk("fwd_x0", {30'd0, ForwardAE}, 32'd0); tick();
        RdM = 3; RdW = 9; Rs1E = 9; Rs2E = 3;
        step("fwd_mixed");
        idle();

        // Load-use for one cycle
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        #3;
        chk("loaduse.stall", {28'd0, StallF, StallD, StallE, StallM}, 32'hC);
        chk("loaduse.flush", {30'd0, FlushD, FlushE}, 32'h1);
        check_now("loaduse");
        tick();
        idle();
        step("after_loaduse");

        // Branch taken with no hazard
        PCSrcE = 1;
        #3;
        chk("branch.flush", {30'd0, FlushD, FlushE}, 32'h3);
        chk("branch.stall", {28'd0, StallF, StallD, StallE, StallM}, 32'h0);
        check_now("branch");
        tick();
        // Load-use and branch together
        ResultSrcE = 2'b01; RdE = 4; Rs1D = 4;
        #3;
        chk("lu_br.flush", {30'd0, FlushD, FlushE}, 32'h3);
        chk("lu_br.stall", {28'd0, StallF, StallD, StallE, StallM}, 32'hC);
        tick();
        idle();

        // Memory wait for three cycles, then ready
        MemReqM = 1;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("memwait.stall", {28'd0, StallF, StallD, StallE, StallM}, 32'hF);
            check_now("memwait");
            tick();
        end
        MemReadyM = 1;
        #3;
        chk("memready.stall", {28'd0, StallF, StallD, StallE, StallM}, 32'h0);
        tick();
        idle();
        step("after_mem");

        // WAIT state holds the stall even when the request line drops
        MemReqM = 1;
        step("wait_enter");
        MemReqM = 0;
        #3;
        chk("wait_state.stall", {28'd0, StallF, StallD, StallE, StallM}, 32'hF);
        tick();
        MemReadyM = 1;
        step("wait_done");
        idle();

        // Branch during a memory wait: no flush until the ready cycle
        MemReqM = 1; PCSrcE = 1;
        for (int i = 0; i < 2; i++) begin
            #3;
            chk("overlap.flush_wait", {30'd0, FlushD, FlushE}, 32'h0);
            tick();
        end
        MemReadyM = 1;
        #3;
        chk("overlap.flush_ready", {30'd0, FlushD, FlushE}, 32'h3);
        check_now("overlap");
        tick();
        idle();

        // Timeout: 300 cycles of unanswered request
        MemReqM = 1;
        for (int i = 0; i < 300; i++) begin
            #3;
            if (i == 256) chk("timeout.not_yet", {31'd0, MemTimeout}, 32'd0);
            if (i == 257) chk("timeout.set", {31'd0, MemTimeout}, 32'd1);
            check_now("timeout_run");
            tick();
        end
        chk("timeout.stall", {28'd0, StallF, StallD, StallE, StallM}, 32'hF);
        idle();
        MemReadyM = 1;
        step("error_absorbing");
        idle();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst.timeout", {31'd0, MemTimeout}, 32'd0);
        chk("async_rst.stall", {28'd0, StallF, StallD, StallE, StallM}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst");

        // Reset during WAIT leaves no residual stall
        MemReqM = 1;
        step("wait_before_rst");
        step("wait_before_rst2");
        idle();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        #3;
        chk("rst_in_wait.stall", {28'd0, StallF, StallD, StallE, StallM}, 32'h0);
        check_now("rst_in_wait");
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            Rs1D = 5'($urandom_range(0, 3));
            Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3));
            Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3));
            RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE     = ($urandom_range(0, 3) == 0);
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            MemReqM    = ($urandom_range(0, 2) == 0);
            MemReadyM  = 1'($urandom_range(0, 1));
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
